// File: rtl/round_robin_arbiter_pkg.sv
// round_robin_arbiter_pkg: shared types for the round-robin arbiter
package round_robin_arbiter_pkg;
  typedef enum logic {
    IDLE,
    GRANTED
  } state_t;
endpackage

// File: rtl/round_robin_arbiter_small_first_one.sv
// small_first_one: isolates the lowest set bit of a vector (all-zero if none)
module small_first_one #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] vec,
  output logic [WIDTH-1:0] first
);
  assign first = vec & (~vec + WIDTH'(1));
endmodule

// File: rtl/round_robin_arbiter.sv
// round_robin_arbiter: registered one-hot round-robin arbiter with optional per-owner hold limit
module round_robin_arbiter
  import round_robin_arbiter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX_HOLD = 0
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic [WIDTH-1:0]         requests,
  output logic [WIDTH-1:0]         grant,
  output logic [$clog2(WIDTH)-1:0] grant_index,
  output logic                     busy
);
  localparam int IW = $clog2(WIDTH);
  localparam int CW = MAX_HOLD > 1 ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_TOP = CW'(MAX_HOLD > 0 ? MAX_HOLD - 1 : 0);
  state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, win_idx, idx_d;
  logic [CW-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] grant_d, mask, cand, win_hi, win_lo, win;
  logic owner_req, others, forced, keep, busy_d;
  for (genvar i = 0; i < WIDTH; i++) begin : g_mask
    assign mask[i] = ptr_q <= IW'(i);
  end
  assign owner_req = state_q == GRANTED && |(requests & grant);
  assign others    = |(requests & ~grant);
  // a forced handoff must skip the current owner even though it still requests
  assign forced    = MAX_HOLD > 0 && owner_req && others && hold_q == HOLD_TOP;
  assign keep      = owner_req && !forced;
  assign cand      = forced ? requests & ~grant : requests;
  small_first_one #(.WIDTH(WIDTH)) u_sfo_hi (.vec(cand & mask), .first(win_hi));
  small_first_one #(.WIDTH(WIDTH)) u_sfo_lo (.vec(cand), .first(win_lo));
  always_comb begin
    win = |win_hi ? win_hi : win_lo;
    win_idx = '0;
    for (int i = 0; i < WIDTH; i++) win_idx |= win[i] ? IW'(i) : '0;
    state_d = keep ? state_q : (|win ? GRANTED : IDLE);
    grant_d = keep ? grant : win;
    idx_d   = keep ? grant_index : win_idx;
    busy_d  = |grant_d;
    ptr_d   = keep || !(|win) ? ptr_q : (win_idx == IW'(WIDTH - 1) ? '0 : win_idx + 1'b1);
    hold_d  = !keep ? '0 : (hold_q == HOLD_TOP ? hold_q : hold_q + 1'b1);
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      grant       <= '0;
      grant_index <= '0;
      busy        <= 1'b0;
      ptr_q       <= '0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      grant       <= grant_d;
      grant_index <= idx_d;
      busy        <= busy_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
    end
  end
endmodule

// File: tb/tb_round_robin_arbiter.sv
// tb_round_robin_arbiter: directed and random checks of two arbiters (hold limit 4 and unlimited)
module tb_round_robin_arbiter;
  localparam int W = 4;
  logic clock = 1'b0;
  logic resetn = 1'b1;
  logic [W-1:0] requests = '0;
  logic [W-1:0] grant_a, grant_b;
  logic [1:0] idx_a, idx_b;
  logic busy_a, busy_b;
  int n_tests = 0;
  int n_fail = 0;
  int owner [2];
  int ptr [2];
  int hold [2];
  int max_hold [2] = '{4, 0};
  always #5 clock = ~clock;
  round_robin_arbiter #(.WIDTH(W), .MAX_HOLD(4)) dut_a (
    .clock(clock), .resetn(resetn), .requests(requests),
    .grant(grant_a), .grant_index(idx_a), .busy(busy_a));
  round_robin_arbiter #(.WIDTH(W), .MAX_HOLD(0)) dut_b (
    .clock(clock), .resetn(resetn), .requests(requests),
    .grant(grant_b), .grant_index(idx_b), .busy(busy_b));
  task automatic check(string tag, int got, int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      owner[k] = -1;
      ptr[k] = 0;
      hold[k] = 0;
    end
  endfunction
  function automatic void model_step(int k, logic [W-1:0] r);
    int others;
    bit has;
    others = 0;
    has = owner[k] >= 0 && r[owner[k]];
    for (int i = 0; i < W; i++) if (r[i] && i != owner[k]) others++;
    if (has && !(max_hold[k] > 0 && hold[k] >= max_hold[k] - 1 && others > 0)) begin
      if (hold[k] < max_hold[k] - 1) hold[k]++;
    end else begin
      int excl;
      int pick;
      excl = has ? owner[k] : -1;
      pick = -1;
      for (int j = 0; j < W; j++) begin
        int c;
        c = (ptr[k] + j) % W;
        if (pick < 0 && r[c] && c != excl) pick = c;
      end
      hold[k] = 0;
      owner[k] = pick;
      if (pick >= 0) ptr[k] = (pick + 1) % W;
    end
  endfunction
  function automatic int exp_grant(int k);
    return owner[k] < 0 ? 0 : (1 << owner[k]);
  endfunction
  task automatic check_model();
    check("model_grant_a", int'(grant_a), exp_grant(0));
    check("model_index_a", int'(idx_a), owner[0] < 0 ? 0 : owner[0]);
    check("model_busy_a", int'(busy_a), int'(owner[0] >= 0));
    check("model_grant_b", int'(grant_b), exp_grant(1));
    check("model_index_b", int'(idx_b), owner[1] < 0 ? 0 : owner[1]);
    check("model_busy_b", int'(busy_b), int'(owner[1] >= 0));
  endtask
  task automatic tick(logic [W-1:0] r);
    requests = r;
    @(posedge clock);
    model_step(0, r);
    model_step(1, r);
    #1;
    check_model();
  endtask
  task automatic pulse_reset();
    #2 resetn = 1'b0;
    #1;
    model_reset();
    check("async_rst_grant_a", int'(grant_a), 0);
    check("async_rst_grant_b", int'(grant_b), 0);
    check_model();
    #1 resetn = 1'b1;
  endtask
  initial begin
    logic [W-1:0] r;
    model_reset();
    #1 resetn = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_grant", int'(grant_a), 0);
    check("reset_index", int'(idx_a), 0);
    check("reset_busy", int'(busy_a), 0);
    check_model();
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;
    tick(4'b1010);
    check("first_grant", int'(grant_a), 4'b0010);
    check("first_index", int'(idx_a), 1);
    check("first_busy", int'(busy_a), 1);
    tick(4'b1001);
    check("wrap_handoff", int'(grant_a), 4'b1000);
    check("wrap_index", int'(idx_a), 3);
    tick(4'b0000);
    check("idle_after_drop", int'(grant_a), 0);
    for (int t = 1; t <= 20; t++) begin
      tick(4'b1111);
      check("rotate_a", int'(grant_a), 1 << (((t - 1) / 4) % 4));
      check("unlimited_b", int'(grant_b), 4'b0001);
    end
    tick(4'b0000);
    for (int t = 0; t < 10; t++) begin
      tick(4'b0100);
      check("sole_owner", int'(grant_a), 4'b0100);
    end
    tick(4'b0000);
    for (int t = 0; t < 20; t++) begin
      tick(4'b0011);
      check("no_limit_hold", int'(grant_b), 4'b0001);
    end
    tick(4'b0010);
    check("no_limit_release", int'(grant_b), 4'b0010);
    tick(4'b0100);
    check("pre_reset_grant", int'(grant_a), 4'b0100);
    pulse_reset();
    tick(4'b1100);
    check("post_reset_ptr0", int'(grant_a), 4'b0100);
    check("post_reset_ptr0_b", int'(grant_b), 4'b0100);
    r = 4'b1100;
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < W; i++) if ($urandom_range(0, 3) == 0) r[i] = ~r[i];
      if ($urandom_range(0, 7) == 0) r = 4'(1 << $urandom_range(0, W - 1)) | r;
      tick(r);
      if ($urandom_range(0, 79) == 0) pulse_reset();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
